// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that lets several requesters share one FIFO write port.
// A grant holds for one burst: it ends on the requester's last marker or at MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int DLY        = 1,
    parameter int FIFO_WIDTH = 8,
    parameter int REQ_NUM    = 4,
    parameter int MAX_BURST  = 16,
    parameter int IDX        = $clog2(REQ_NUM)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [REQ_NUM-1:0]            req_valid_i,
    input  logic [REQ_NUM*FIFO_WIDTH-1:0] req_data_i,
    input  logic [REQ_NUM-1:0]            req_last_i,
    output logic [REQ_NUM-1:0]            req_ready_o,
    input  logic                          full_i,
    output logic                          wr_en_o,
    output logic [FIFO_WIDTH-1:0]         wr_data_o,
    output logic [REQ_NUM-1:0]            gnt_o,
    output logic [IDX-1:0]                gnt_idx_o,
    output logic                          busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [IDX-1:0] LAST_IDX_RST = IDX'(REQ_NUM - 1);
    localparam logic [8:0]     CNT_LAST     = 9'(MAX_BURST - 1);

    // DLY is kept for interface compatibility; the synthesizable registers carry no modelled delay.
    if (DLY < 0 || REQ_NUM < 2 || REQ_NUM > 8 || MAX_BURST < 1 || MAX_BURST > 256 ||
        IDX < $clog2(REQ_NUM)) begin : g_bad_params
        $error("fifo_wr_arbiter: parameter out of range");
    end

    state_t               state_q, state_d;
    logic [REQ_NUM-1:0]   gnt_q, gnt_d;
    logic [IDX-1:0]       gnt_idx_q, gnt_idx_d;
    logic [IDX-1:0]       last_idx_q, last_idx_d;
    logic [8:0]           beat_cnt_q, beat_cnt_d;

    logic [IDX-1:0]       win_idx;
    logic                 win_found;
    logic [FIFO_WIDTH-1:0] g_data;
    logic                 g_valid;
    logic                 g_last;
    logic                 beat;
    logic                 burst_end;

    // Winner search starts just after the previous grant and wraps, so nobody starves.
    always_comb begin : p_round_robin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            cand = (int'(last_idx_q) + i) % REQ_NUM;
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX'(cand);
            end
        end
    end

    // The one-hot grant register steers the granted requester's word; it is zero while idle.
    always_comb begin : p_grant_mux
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (gnt_q[k]) begin
                g_data  = req_data_i[k*FIFO_WIDTH +: FIFO_WIDTH];
                g_valid = req_valid_i[k];
                g_last  = req_last_i[k];
            end
        end
    end

    assign beat      = (state_q == GRANT) && g_valid && !full_i;
    assign burst_end = g_last || (beat_cnt_q == CNT_LAST);

    assign wr_en_o     = beat;
    assign wr_data_o   = (state_q == GRANT) ? g_data : '0;
    assign req_ready_o = (state_q == GRANT) ? (gnt_q & {REQ_NUM{!full_i}}) : '0;
    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign busy_o      = (state_q == GRANT);

    always_comb begin : p_next_state
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = GRANT;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    gnt_idx_d        = win_idx;
                    beat_cnt_d       = '0;
                end
            end
            GRANT: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    // Dropping to IDLE here forces one idle cycle before any re-grant.
                    if (burst_end) begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        last_idx_d = gnt_idx_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin : p_regs
        if (!rst_n_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            last_idx_q <= LAST_IDX_RST;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: per-requester burst sources, a burst-level
// reference model of the arbiter, and a per-requester write scoreboard.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 16;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n_i;
    logic [N-1:0]   req_valid_i;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic           full_i;
    logic           wr_en_o;
    logic [W-1:0]   wr_data_o;
    logic [N-1:0]   gnt_o;
    logic [IW-1:0]  gnt_idx_o;
    logic           busy_o;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DLY(1), .FIFO_WIDTH(W), .REQ_NUM(N), .MAX_BURST(MB), .IDX(IW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o), .full_i(full_i),
        .wr_en_o(wr_en_o), .wr_data_o(wr_data_o),
        .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o), .busy_o(busy_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the port, who owned it last, beats taken this burst.
    int mOwner = -1;
    int mLast  = N - 1;
    int mIdx   = 0;
    int mBeats = 0;

    // Sources: words left in each requester's burst and the word currently presented.
    int         remain[N];
    logic [W-1:0] curData[N];
    int         wrCount[N];
    int         accCount[N];

    int validPct;
    int newPct;
    int maxLen;

    logic [N-1:0] validV;
    logic [N-1:0] lastV;
    logic         fullV;
    logic         rstV;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rstIn, input logic fullIn);
        for (int k = 0; k < N; k++) begin
            if (remain[k] == 0 && int'($urandom_range(99)) < newPct)
                remain[k] = 1 + int'($urandom_range(maxLen - 1));
            validV[k] = (remain[k] > 0) && (int'($urandom_range(99)) < validPct);
            lastV[k]  = (remain[k] == 1);
            req_data_i[k*W +: W] = curData[k];
        end
        fullV       = fullIn;
        rstV        = rstIn;
        req_valid_i = validV;
        req_last_i  = lastV;
        full_i      = fullIn;
        rst_n_i     = rstIn;
    endtask

    task automatic checkCycle();
        logic [N-1:0] one;
        logic [N-1:0] eGnt;
        logic [N-1:0] eReady;
        logic         eBusy;
        logic         eBeat;
        logic [W-1:0] eData;
        int           o;
        one    = 1;
        o      = mOwner;
        eBusy  = (o >= 0);
        eGnt   = eBusy ? (one << o) : '0;
        eBeat  = eBusy && validV[eBusy ? o : 0] && !fullV;
        eData  = eBusy ? curData[o] : '0;
        eReady = (eBusy && !fullV) ? (one << o) : '0;

        checkOutput("gnt", 32'(gnt_o), 32'(eGnt));
        checkOutput("gnt_idx", 32'(gnt_idx_o), 32'(mIdx));
        checkOutput("busy", 32'(busy_o), 32'(eBusy));
        checkOutput("wr_en", 32'(wr_en_o), 32'(eBeat));
        checkOutput("wr_data", 32'(wr_data_o), 32'(eData));
        checkOutput("ready", 32'(req_ready_o), 32'(eReady));
        checkOutput("wr_while_full", 32'(wr_en_o & full_i), 32'(0));

        if (wr_en_o === 1'b1) begin
            wrCount[gnt_idx_o]++;
            checkOutput("sb_order", 32'(wr_data_o), 32'(curData[gnt_idx_o]));
        end

        // An accepted word advances its source even if reset lands on this edge.
        if (eBeat) begin
            accCount[o]++;
            remain[o]--;
            curData[o] = W'($urandom);
        end

        if (rstV == 1'b0) begin
            mOwner = -1;
            mLast  = N - 1;
            mIdx   = 0;
            mBeats = 0;
        end else if (o < 0) begin
            for (int d = 1; d <= N; d++) begin
                int c;
                c = (mLast + d) % N;
                if (validV[c]) begin
                    mOwner = c;
                    mIdx   = c;
                    mBeats = 0;
                    break;
                end
            end
        end else if (eBeat) begin
            mBeats++;
            if (lastV[o] || mBeats == MB) begin
                mLast  = o;
                mOwner = -1;
            end
        end
    endtask

    task automatic runCycle(input logic rstIn, input logic fullIn);
        @(posedge clk);
        #1;
        applyStimulus(rstIn, fullIn);
        @(negedge clk);
        checkCycle();
    endtask

    task automatic clearSources();
        for (int k = 0; k < N; k++) remain[k] = 0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            remain[k]   = 0;
            curData[k]  = W'($urandom);
            wrCount[k]  = 0;
            accCount[k] = 0;
        end
        validPct    = 100;
        newPct      = 0;
        maxLen      = 1;
        rst_n_i     = 1'b0;
        full_i      = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        validV      = '0;
        lastV       = '0;
        fullV       = 1'b0;
        rstV        = 1'b0;

        // Reset values
        runCycle(1'b0, 1'b0);
        runCycle(1'b0, 1'b0);
        checkOutput("rst_gnt", 32'(gnt_o), 32'(0));
        checkOutput("rst_busy", 32'(busy_o), 32'(0));
        checkOutput("rst_wr_en", 32'(wr_en_o), 32'(0));

        // Requesters 1 and 3 after reset: requester 1 wins after one idle cycle
        remain[1] = 3;
        remain[3] = 3;
        runCycle(1'b1, 1'b0);
        runCycle(1'b1, 1'b0);
        checkOutput("first_gnt", 32'(gnt_o), 32'(4'b0010));
        checkOutput("first_gnt_idx", 32'(gnt_idx_o), 32'(1));
        checkOutput("first_busy", 32'(busy_o), 32'(1));
        for (int i = 0; i < 12; i++) runCycle(1'b1, 1'b0);

        // All requesters always valid with single-word bursts
        newPct = 100;
        maxLen = 1;
        for (int i = 0; i < 20; i++) runCycle(1'b1, 1'b0);

        // Over-long burst from requester 2 is cut at MAX_BURST, requester 0 served next
        newPct = 0;
        clearSources();
        runCycle(1'b0, 1'b0);
        remain[2] = 20;
        for (int i = 0; i < 5; i++) runCycle(1'b1, 1'b0);
        remain[0] = 2;
        for (int i = 0; i < 40; i++) runCycle(1'b1, 1'b0);

        // FIFO full for five cycles in the middle of a burst
        clearSources();
        remain[1] = 10;
        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) runCycle(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) runCycle(1'b1, 1'b0);

        // Reset in the middle of a burst, then restart from the lowest index
        clearSources();
        runCycle(1'b1, 1'b0);
        remain[0] = 10;
        remain[2] = 5;
        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b0);
        runCycle(1'b0, 1'b0);
        runCycle(1'b1, 1'b0);
        checkOutput("post_rst_wr_en", 32'(wr_en_o), 32'(0));
        checkOutput("post_rst_gnt", 32'(gnt_o), 32'(0));
        runCycle(1'b1, 1'b0);
        checkOutput("post_rst_regrant", 32'(gnt_o), 32'(4'b0001));
        for (int i = 0; i < 20; i++) runCycle(1'b1, 1'b0);

        // Random traffic with back-pressure and occasional reset
        validPct = 70;
        newPct   = 10;
        maxLen   = 24;
        for (int i = 0; i < 3000; i++) begin
            runCycle((int'($urandom_range(199)) != 0) ? 1'b1 : 1'b0,
                     (int'($urandom_range(99)) < 15) ? 1'b1 : 1'b0);
        end

        for (int k = 0; k < N; k++)
            checkOutput($sformatf("write_count%0d", k), 32'(wrCount[k]), 32'(accCount[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DLY, default 1: register update delay used in all sequential assignments.
REQ-002 Parameter FIFO_WIDTH, default 8: data word width; matches the FIFO write data width.
REQ-003 Parameter REQ_NUM, default 4: number of requesters, range 2..8.
REQ-004 Parameter MAX_BURST, default 16: maximum beats per grant, range 1..256.
REQ-005 Parameter IDX, default $clog2(REQ_NUM): width of the grant index.
REQ-006 clk_i  input  1: single clock, which is the FIFO write clock.
REQ-007 rst_n_i  input  1: reset; synchronous, active-low.
REQ-008 req_valid_i  input  REQ_NUM: per-requester word-valid.
REQ-009 req_data_i  input  REQ_NUM*FIFO_WIDTH: packed words; requester k occupies bits [k*FIFO_WIDTH +: FIFO_WIDTH].
REQ-010 req_last_i  input  REQ_NUM: per-requester end-of-burst marker, qualified by valid.
REQ-011 req_ready_o  output  REQ_NUM: per-requester word accepted this cycle.
REQ-012 full_i  input  1: FIFO full flag, write-clock domain.
REQ-013 wr_en_o  output  1: FIFO write enable.
REQ-014 wr_data_o  output  FIFO_WIDTH: FIFO write data.
REQ-015 gnt_o  output  REQ_NUM: one-hot current grant; all zero when idle.
REQ-016 gnt_idx_o  output  IDX: binary index of the current or most recent grant.
REQ-017 busy_o  output  1: high while in state GRANT.

Function
REQ-018 The FSM SHALL have two states: IDLE and GRANT.
REQ-019 In IDLE with any req_valid_i set, the FSM SHALL register a winner and enter GRANT on the next edge.
  - Winner: first set bit scanning upward from (last_idx+1) mod REQ_NUM, with wrap.
  - Arbitration latency: 1 cycle.
REQ-020 In IDLE with no requests, state, gnt_o and last_idx SHALL hold.
REQ-021 In GRANT, a beat SHALL be defined as req_valid_i[g] & ~full_i, where g is the granted index.
REQ-022 The beat path SHALL be combinational:
  - wr_en_o = beat; wr_data_o = data of g.
  - req_ready_o[g] = ~full_i; every other ready bit = 0.
REQ-023 Outside GRANT, wr_en_o and req_ready_o SHALL be 0 and wr_data_o SHALL be 0.
REQ-024 A 9-bit beat counter SHALL clear on entry to GRANT and increment on each beat.
REQ-025 GRANT SHALL return to IDLE on the edge of a beat with req_last_i[g]=1 or beat count == MAX_BURST-1; last_idx SHALL update to g on that edge.
REQ-026 When valid drops mid-burst, the grant SHALL hold with no timeout.
REQ-027 While full_i=1, no beat SHALL occur and the counter SHALL hold; wr_en_o SHALL never assert while full_i=1.
REQ-028 At least one IDLE cycle SHALL occur between consecutive grants, including re-grant to the same requester.
REQ-029 gnt_o SHALL be registered, glitch-free, and equal to one-hot(g) throughout GRANT.
REQ-030 Requests from non-granted requesters arriving during GRANT SHALL be held off (ready=0) and considered at the next IDLE.

Reset
REQ-031 With rst_n_i=0 at a clock edge, the block SHALL set state=IDLE, gnt_o=0, gnt_idx_o=0, last_idx=REQ_NUM-1, counter=0 and busy_o=0.
  - Consequently wr_en_o=0, req_ready_o=0 and wr_data_o=0.
REQ-032 Reset asserted mid-burst SHALL abort the burst without a further write from the edge onward; the first grant after reset SHALL go to the lowest-index active requester.

Verification
REQ-033 Reset then req_valid_i=4'b1010 -> one IDLE cycle, then gnt_o=4'b0010, gnt_idx_o=1, busy_o=1.
REQ-034 All four requesters continuously valid with last on every beat -> grant order 0,1,2,3,0; one write per 2 cycles; no starvation.
REQ-035 Requester 2 with 20 beats and no last, MAX_BURST=16 -> exactly 16 writes, then release; requester 2 is re-granted only after other pending requesters are served.
REQ-036 full_i=1 for 5 cycles mid-burst -> wr_en_o=0 and req_ready_o=0 for those cycles; counter frozen; the burst resumes with data order and count preserved.
REQ-037 rst_n_i=0 for 1 cycle at beat 3 of a burst -> wr_en_o=0 from that edge; outputs at reset values; the next grant goes to the lowest active index.
REQ-038 Scoreboard check (every test) -> per-requester FIFO write sequence equals that requester's accepted words in order; wr_en_o&full_i never true.
